// File: rtl/uno_seq.sv
// uno_seq: command sequencer in front of the uno PE.
// A MAC command streams L operand pairs into uno as a dot product with a bias.
// A div/exp/log command runs a Horner evaluation over a per-op coefficient
// bank. res_valid pulses when uno's output register holds the final result.
module uno_seq #(
  parameter int MAC_BW = 12,
  parameter int ORDER  = 3,
  parameter int LEN_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [MAC_BW-1:0]            cmd_x,
  input  logic [MAC_BW-1:0]            cmd_y,
  input  logic [2*MAC_BW-1:0]          cmd_z,
  input  logic [LEN_W-1:0]             cmd_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MAC_BW-1:0]            in_a,
  input  logic [MAC_BW-1:0]            in_b,
  input  logic                         cw_en,
  input  logic [1:0]                   cw_op,
  input  logic [$clog2(ORDER+1)-1:0]   cw_idx,
  input  logic [MAC_BW-1:0]            cw_data,
  output logic [1:0]                   pe_op,
  output logic [MAC_BW-1:0]            pe_x,
  output logic [MAC_BW-1:0]            pe_y,
  output logic [2*MAC_BW-1:0]          pe_z,
  output logic [MAC_BW-1:0]            pe_coeff,
  output logic                         pe_first,
  output logic                         pe_last,
  output logic                         pe_acc_en,
  output logic                         busy,
  output logic                         res_valid
);

  localparam int IW = $clog2(ORDER + 1);
  // Counter covers both the MAC element count and the Horner step index.
  localparam int CW = ((LEN_W > IW) ? LEN_W : IW) + 1;
  localparam logic [CW-1:0] N_C    = CW'(ORDER);
  localparam logic [1:0]    OP_MAC = 2'b00;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]        state;
  logic [1:0]        op_q;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     len_q;
  logic              fin;       // pe_* currently shows the final issue cycle
  logic              acc_seen;  // at least one MAC issue already presented
  logic [MAC_BW-1:0] coef [0:3][0:ORDER];

  logic              accept;
  logic              is_mac;
  logic              cw_wr;
  logic [MAC_BW-1:0] lead_c;
  logic [MAC_BW-1:0] next_c;
  logic [MAC_BW-1:0] rd_c;
  logic [IW-1:0]     rd_idx;

  // Handshakes, write qualification and coefficient lookups.
  always_comb begin
    // NOTE: every signal gets a value before any condition, so no latch is inferred.
    busy      = (state != S_IDLE);
    cmd_ready = (state == S_IDLE);
    accept    = cmd_valid && cmd_ready;
    is_mac    = (op_q == OP_MAC);
    in_ready  = (state == S_RUN) && is_mac && (cnt < len_q);
    cw_wr     = cw_en && !busy && (cw_op != 2'b00) && (int'(cw_idx) <= ORDER);
    // Issue 0 is registered on the accept edge, so a same-cycle write is forwarded.
    lead_c    = coef[cmd_op][ORDER];
    if (cw_wr && (cw_op == cmd_op) && (cw_idx == IW'(ORDER)))
      lead_c = cw_data;
    next_c    = coef[cmd_op][ORDER-1];
    if (cw_wr && (cw_op == cmd_op) && (cw_idx == IW'(ORDER - 1)))
      next_c = cw_data;
    rd_idx    = IW'(ORDER - 1) - cnt[IW-1:0];
    rd_c      = coef[op_q][rd_idx];
  end

  // Coefficient bank: writable only while idle, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the bank is small and must read as zero after reset, so it is reset explicitly.
      for (int b = 0; b < 4; b++)
        for (int k = 0; k <= ORDER; k++)
          coef[b][k] <= '0;
    end else if (cw_wr) begin
      coef[cw_op][cw_idx] <= cw_data;
    end
  end

  // Sequencer FSM and registered uno drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state     <= S_IDLE;
      op_q      <= '0;
      cnt       <= '0;
      len_q     <= '0;
      fin       <= 1'b0;
      acc_seen  <= 1'b0;
      pe_op     <= '0;
      pe_x      <= '0;
      pe_y      <= '0;
      pe_z      <= '0;
      pe_coeff  <= '0;
      pe_first  <= 1'b0;
      pe_last   <= 1'b0;
      pe_acc_en <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_RUN;
            op_q      <= cmd_op;
            len_q     <= (cmd_len == '0) ? CW'(1) : CW'(cmd_len);
            fin       <= 1'b0;
            acc_seen  <= 1'b0;
            pe_op     <= cmd_op;
            pe_last   <= 1'b0;
            pe_acc_en <= 1'b0;
            if (cmd_op == OP_MAC) begin
              // First RUN cycle is a setup cycle: bias presented, nothing issued yet.
              pe_x     <= '0;
              pe_y     <= '0;
              pe_z     <= cmd_z;
              pe_coeff <= '0;
              pe_first <= 1'b0;
              cnt      <= '0;
            end else begin
              pe_x     <= cmd_x;
              pe_y     <= cmd_y;
              pe_z     <= {{MAC_BW{1'b0}}, lead_c};
              pe_coeff <= next_c;
              pe_first <= 1'b1;
              cnt      <= CW'(1);
            end
          end
        end
        S_RUN: begin
          if (fin) begin
            state     <= S_FLUSH;
            pe_x      <= '0;
            pe_y      <= '0;
            pe_z      <= '0;
            pe_coeff  <= '0;
            pe_first  <= 1'b0;
            pe_last   <= 1'b0;
            pe_acc_en <= 1'b0;
          end else if (is_mac) begin
            if (in_ready) begin
              pe_x      <= in_valid ? in_a : '0;
              pe_y      <= in_valid ? in_b : '0;
              pe_acc_en <= acc_seen;
              acc_seen  <= 1'b1;
              if (in_valid) begin
                cnt <= cnt + CW'(1);
                if ((cnt + CW'(1)) == len_q)
                  fin <= 1'b1;
              end
            end
          end else begin
            pe_first <= 1'b0;
            pe_z     <= '0;
            pe_coeff <= (cnt == N_C) ? '0 : rd_c;
            pe_last  <= (cnt == N_C);
            fin      <= (cnt == N_C);
            cnt      <= cnt + CW'(1);
          end
        end
        S_FLUSH: begin
          state     <= S_IDLE;
          res_valid <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
